// File: rtl/sysid_checker.sv
// ============================================================================
//  Module   : sysid_checker
//  Purpose  : Reads the system ID (word 0) and build timestamp (word 1) from
//             an Avalon-MM sysid slave on request. Compares both against
//             expected constants and reports the result. Each read is bounded
//             by a per-read waitrequest timeout.
//  Ports    :
//    clock           - single clock, rising edge
//    reset_n         - asynchronous active-low reset
//    start           - request a check sequence (honoured in IDLE only)
//    avm_address     - Avalon-MM word address (0 = ID, 1 = timestamp)
//    avm_read        - Avalon-MM read strobe
//    avm_readdata    - read data from slave
//    avm_waitrequest - slave stall
//    busy            - sequence in progress (RD_ID / RD_TS)
//    done            - one-cycle completion pulse
//    id_ok / ts_ok   - comparison results of the last sequence
//    timeout_err     - last sequence aborted on timeout
//    captured_id/_ts - last values read
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID = 32'd0,
   parameter logic [31:0] EXPECTED_TS = 32'd1521151335,
   parameter logic [7:0]  TIMEOUT     = 8'd255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout_err,
   output logic [31:0] captured_id,
   output logic [31:0] captured_ts
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RD_ID = 2'd1,
      S_RD_TS = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_wait_cnt;
   logic        r_id_ok;
   logic        r_ts_ok;
   logic        r_timeout_err;
   logic [31:0] r_captured_id;
   logic [31:0] r_captured_ts;

   logic        w_in_read;
   logic        w_expired;

   assign w_in_read = (r_state == S_RD_ID) || (r_state == S_RD_TS);
   // The counter holds the number of stalls already seen on this read, so a
   // stall arriving while it equals TIMEOUT is stall number TIMEOUT+1.
   assign w_expired = w_in_read && avm_waitrequest && (r_wait_cnt == TIMEOUT);

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic and state-decoded bus/status outputs
   always_comb begin
      w_next      = r_state;
      avm_read    = 1'b0;
      avm_address = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = S_RD_ID;
            end
         end
         S_RD_ID: begin
            avm_read = 1'b1;
            busy     = 1'b1;
            if (w_expired) begin
               w_next = S_FIN;
            end else if (!avm_waitrequest) begin
               w_next = S_RD_TS;
            end
         end
         S_RD_TS: begin
            avm_read    = 1'b1;
            avm_address = 1'b1;
            busy        = 1'b1;
            if (w_expired || !avm_waitrequest) begin
               w_next = S_FIN;
            end
         end
         S_FIN: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Wait counter, captured data and result flags
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wait_cnt    <= 8'd0;
         r_id_ok       <= 1'b0;
         r_ts_ok       <= 1'b0;
         r_timeout_err <= 1'b0;
         r_captured_id <= 32'd0;
         r_captured_ts <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_wait_cnt    <= 8'd0;
                  r_id_ok       <= 1'b0;
                  r_ts_ok       <= 1'b0;
                  r_timeout_err <= 1'b0;
               end
            end
            S_RD_ID: begin
               if (w_expired) begin
                  r_timeout_err <= 1'b1;
               end else if (avm_waitrequest) begin
                  if (r_wait_cnt != 8'hFF) begin
                     r_wait_cnt <= r_wait_cnt + 8'd1;
                  end
               end else begin
                  r_captured_id <= avm_readdata;
                  r_wait_cnt    <= 8'd0;
               end
            end
            S_RD_TS: begin
               if (w_expired) begin
                  r_timeout_err <= 1'b1;
               end else if (avm_waitrequest) begin
                  if (r_wait_cnt != 8'hFF) begin
                     r_wait_cnt <= r_wait_cnt + 8'd1;
                  end
               end else begin
                  r_captured_ts <= avm_readdata;
                  r_id_ok       <= (r_captured_id == EXPECTED_ID);
                  r_ts_ok       <= (avm_readdata == EXPECTED_TS);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign id_ok       = r_id_ok;
   assign ts_ok       = r_ts_ok;
   assign timeout_err = r_timeout_err;
   assign captured_id = r_captured_id;
   assign captured_ts = r_captured_ts;

endmodule

`default_nettype wire

// File: tb/tb_sysid_checker.sv
// ============================================================================
//  Module   : tb_sysid_checker
//  Purpose  : Self-checking bench for sysid_checker. A behavioural sysid
//             slave with a programmable number of stall cycles per read feeds
//             the DUT. Expected results are queued when a sequence is launched
//             and compared when done is observed.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sysid_checker;

   localparam logic [31:0] C_TS      = 32'd1521151335;
   localparam logic [7:0]  C_TIMEOUT = 8'd4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        avm_address;
   logic        avm_read;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;
   logic        busy;
   logic        done;
   logic        id_ok;
   logic        ts_ok;
   logic        timeout_err;
   logic [31:0] captured_id;
   logic [31:0] captured_ts;

   int checks = 0;
   int errors = 0;

   // Slave model
   logic [31:0] slv_id = 32'd0;
   logic [31:0] slv_ts = C_TS;
   int          stall_n = 0;
   logic        stuck = 1'b0;
   int          wcnt;

   always #5 clock = ~clock;

   assign avm_readdata    = avm_address ? slv_ts : slv_id;
   assign avm_waitrequest = avm_read && (stuck || (wcnt < stall_n));

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n)                        wcnt <= 0;
      else if (avm_read && avm_waitrequest) wcnt <= wcnt + 1;
      else                                 wcnt <= 0;
   end

   sysid_checker #(
      .EXPECTED_ID (32'd0),
      .EXPECTED_TS (C_TS),
      .TIMEOUT     (C_TIMEOUT)
   ) u_dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .start           (start),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest),
      .busy            (busy),
      .done            (done),
      .id_ok           (id_ok),
      .ts_ok           (ts_ok),
      .timeout_err     (timeout_err),
      .captured_id     (captured_id),
      .captured_ts     (captured_ts)
   );

   // Scoreboard
   typedef struct {
      logic [2:0]  flags;   // {id_ok, ts_ok, timeout_err}
      logic [31:0] cid;
      logic [31:0] cts;
      int          cyc;
      int          busy_n;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl_cid = 32'd0;
   logic [31:0] mdl_cts = 32'd0;

   // Observations from the last run_seq
   int          obs_cyc;
   int          obs_busy;
   bit          obs_unstable;
   bit          obs_addr1;
   bit          obs_hung;
   logic [2:0]  obs_flags;
   logic [31:0] obs_cid;
   logic [31:0] obs_cts;

   // Reference model of one sequence given the current slave settings
   task automatic push_expect();
      exp_t e;
      if (stuck) begin
         e.flags  = 3'b001;
         e.cyc    = int'(C_TIMEOUT) + 2;
         e.busy_n = int'(C_TIMEOUT) + 1;
      end else begin
         mdl_cid  = slv_id;
         mdl_cts  = slv_ts;
         e.flags  = {(slv_id == 32'd0), (slv_ts == C_TS), 1'b0};
         e.cyc    = 3 + 2 * stall_n;
         e.busy_n = 2 + 2 * stall_n;
      end
      e.cid = mdl_cid;
      e.cts = mdl_cts;
      sb.push_back(e);
   endtask

   // Pulse start at a negedge and observe until done (bounded); ends in IDLE
   task automatic run_seq();
      bit   prev_stall;
      logic prev_addr;
      obs_cyc = 0; obs_busy = 0; obs_unstable = 0; obs_addr1 = 0; obs_hung = 0;
      obs_flags = 3'bxxx; obs_cid = 'x; obs_cts = 'x;
      prev_stall = 0; prev_addr = 1'b0;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int n = 1; n <= 200; n++) begin
         obs_cyc = n;
         if (prev_stall && (avm_read !== 1'b1 || avm_address !== prev_addr)) obs_unstable = 1;
         if (avm_address === 1'b1) obs_addr1 = 1;
         if (busy === 1'b1) obs_busy++;
         if (done === 1'b1) begin
            obs_flags = {id_ok, ts_ok, timeout_err};
            obs_cid   = captured_id;
            obs_cts   = captured_ts;
            @(negedge clock);
            return;
         end
         prev_stall = (avm_read === 1'b1) && (avm_waitrequest === 1'b1);
         prev_addr  = avm_address;
         @(negedge clock);
      end
      obs_hung = 1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if ({avm_address, avm_read, busy, done, id_ok, ts_ok, timeout_err, captured_id, captured_ts} !== 71'd0) begin
         errors++;
         $display("FAIL reset_outputs: got addr=%b rd=%b busy=%b done=%b flags=%b%b%b id=%h ts=%h, expected all 0",
                  avm_address, avm_read, busy, done, id_ok, ts_ok, timeout_err, captured_id, captured_ts);
      end
      reset_n = 1'b1;
      @(negedge clock);
      checks++;
      if (avm_read !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: rd=%b busy=%b after release, expected 0/0", avm_read, busy);
      end
   endtask

   task automatic test_nominal(input logic [31:0] id, input logic [31:0] ts, input string tag);
      exp_t e;
      slv_id = id; slv_ts = ts; stall_n = 0; stuck = 1'b0;
      push_expect();
      run_seq();
      e = sb.pop_front();
      checks++;
      if (obs_hung || obs_cyc != e.cyc) begin
         errors++; $display("FAIL %s_latency: done at cycle %0d (hung=%0d), expected %0d", tag, obs_cyc, obs_hung, e.cyc);
      end
      checks++;
      if (obs_busy != e.busy_n) begin
         errors++; $display("FAIL %s_busy: busy for %0d cycles, expected %0d", tag, obs_busy, e.busy_n);
      end
      checks++;
      if (obs_flags !== e.flags) begin
         errors++; $display("FAIL %s_flags: id_ok/ts_ok/timeout=%b, expected %b", tag, obs_flags, e.flags);
      end
      checks++;
      if ({obs_cid, obs_cts} !== {e.cid, e.cts}) begin
         errors++; $display("FAIL %s_captured: id=%h ts=%h, expected id=%h ts=%h", tag, obs_cid, obs_cts, e.cid, e.cts);
      end
   endtask

   task automatic test_wait_states();
      exp_t e;
      slv_id = 32'd0; slv_ts = C_TS; stall_n = 3; stuck = 1'b0;
      push_expect();
      run_seq();
      e = sb.pop_front();
      checks++;
      if (obs_hung || obs_cyc != e.cyc) begin
         errors++; $display("FAIL wait_latency: done at cycle %0d (hung=%0d), expected %0d", obs_cyc, obs_hung, e.cyc);
      end
      checks++;
      if (obs_unstable) begin
         errors++; $display("FAIL wait_stable: address/read changed during stall (unstable=1), expected 0");
      end
      checks++;
      if (obs_flags !== e.flags || obs_busy != e.busy_n) begin
         errors++; $display("FAIL wait_result: flags=%b busy=%0d, expected flags=%b busy=%0d", obs_flags, obs_busy, e.flags, e.busy_n);
      end
      stall_n = 0;
   endtask

   task automatic test_timeout();
      exp_t e;
      stall_n = 0; stuck = 1'b1;
      push_expect();
      run_seq();
      e = sb.pop_front();
      stuck = 1'b0;
      checks++;
      if (obs_hung || obs_cyc != e.cyc) begin
         errors++; $display("FAIL timeout_latency: done at cycle %0d (hung=%0d), expected %0d", obs_cyc, obs_hung, e.cyc);
      end
      checks++;
      if (obs_flags !== e.flags) begin
         errors++; $display("FAIL timeout_flags: id_ok/ts_ok/timeout=%b, expected %b", obs_flags, e.flags);
      end
      checks++;
      if (obs_addr1 || obs_busy != e.busy_n) begin
         errors++; $display("FAIL timeout_addr: addr1_seen=%0d busy=%0d, expected 0 and %0d", obs_addr1, obs_busy, e.busy_n);
      end
      checks++;
      if ({obs_cid, obs_cts} !== {e.cid, e.cts}) begin
         errors++; $display("FAIL timeout_hold: id=%h ts=%h, expected id=%h ts=%h", obs_cid, obs_cts, e.cid, e.cts);
      end
   endtask

   task automatic test_back_to_back();
      logic [12:0] done_mask;
      logic [12:0] exp_mask;
      int          busy_n;
      slv_id = 32'd0; slv_ts = C_TS; stall_n = 0; stuck = 1'b0;
      done_mask = '0; exp_mask = '0;
      // start held high: sequences repeat every 4 cycles (3 active + 1 IDLE)
      start = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clock);
         done_mask[n] = (done === 1'b1);
         exp_mask[n]  = ((n % 4) == 3);
      end
      start = 1'b0;
      @(negedge clock);
      checks++;
      if (done_mask !== exp_mask) begin
         errors++; $display("FAIL b2b_done_pattern: done cycles=%b, expected %b", done_mask, exp_mask);
      end
      checks++;
      if ({id_ok, ts_ok, timeout_err} !== 3'b110) begin
         errors++; $display("FAIL b2b_flags: flags=%b, expected 110", {id_ok, ts_ok, timeout_err});
      end
      // start re-asserted during RD_TS and FIN must be dropped
      busy_n = 0;
      start = 1'b1;
      @(negedge clock); start = 1'b0; busy_n += int'(busy === 1'b1);
      @(negedge clock); start = 1'b1; busy_n += int'(busy === 1'b1);
      @(negedge clock); busy_n += int'(busy === 1'b1);
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL ignore_done: done=%b at cycle 3, expected 1", done);
      end
      @(negedge clock); start = 1'b0;
      for (int n = 0; n < 5; n++) begin
         busy_n += int'(busy === 1'b1);
         @(negedge clock);
      end
      checks++;
      if (busy_n != 2) begin
         errors++; $display("FAIL ignore_start: busy for %0d cycles, expected 2", busy_n);
      end
   endtask

   task automatic test_reset_mid_read();
      int rd_n;
      slv_id = 32'd0; slv_ts = C_TS; stall_n = 0; stuck = 1'b0;
      start = 1'b1;
      @(negedge clock); start = 1'b0;
      @(negedge clock); stuck = 1'b1;
      #1;
      checks++;
      if (avm_read !== 1'b1 || avm_address !== 1'b1 || avm_waitrequest !== 1'b1) begin
         errors++; $display("FAIL rst_pre: rd=%b addr=%b wait=%b, expected 1/1/1", avm_read, avm_address, avm_waitrequest);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({avm_address, avm_read, busy, done, id_ok, ts_ok, timeout_err, captured_id, captured_ts} !== 71'd0) begin
         errors++;
         $display("FAIL rst_async: addr=%b rd=%b busy=%b done=%b flags=%b%b%b id=%h ts=%h, expected all 0",
                  avm_address, avm_read, busy, done, id_ok, ts_ok, timeout_err, captured_id, captured_ts);
      end
      mdl_cid = 32'd0; mdl_cts = 32'd0;
      @(negedge clock);
      reset_n = 1'b1; stuck = 1'b0;
      rd_n = 0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clock);
         rd_n += int'(avm_read !== 1'b0 || busy !== 1'b0);
      end
      checks++;
      if (rd_n != 0) begin
         errors++; $display("FAIL rst_no_read: read/busy seen in %0d cycles after release, expected 0", rd_n);
      end
   endtask

   initial begin
      test_reset();
      test_nominal(32'd0, C_TS, "nominal");
      test_nominal(32'h0000_0005, C_TS, "bad_id");
      test_nominal(32'd0, 32'h1234_5678, "bad_ts");
      test_wait_states();
      test_timeout();
      test_back_to_back();
      test_reset_mid_read();
      test_nominal(32'd0, C_TS, "post_reset");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
